// File: rtl/lifo_stack_if.sv
// lifo_stack_if: handshake and array-command bundle for the LIFO stack controller.
//   master : request side (push/pop/flush/err_clr/din) plus the array's top-entry
//            value (sr_top); it observes every status output.
//   slave  : the controller. It drives the array command (sr_mode/sr_din), the popped
//            data (dout/dout_valid), occupancy (count/empty/full), busy and the
//            sticky error flags.
// Request semantics: push, pop, flush and err_clr are level requests. The controller
// samples them on every rising clk edge, so each one lasts exactly as many cycles as
// it is held. There is no ready/backpressure path. While busy=1 the controller ignores
// requests. dout is qualified by dout_valid, a single-cycle pulse.
interface lifo_stack_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             push;
  logic             pop;
  logic             flush;
  logic             err_clr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] sr_top;
  logic [1:0]       sr_mode;
  logic [WIDTH-1:0] sr_din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             busy;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, flush, err_clr, din, sr_top,
    input  sr_mode, sr_din, dout, dout_valid, count, empty, full, busy,
           overflow, underflow
  );

  modport slave (
    input  push, pop, flush, err_clr, din, sr_top,
    output sr_mode, sr_din, dout, dout_valid, count, empty, full, busy,
           overflow, underflow
  );
endinterface

// File: rtl/lifo_stack_ctrl.sv
// lifo_stack_ctrl: sequencer for a DEPTH x WIDTH LIFO built from bidirectional
// shift-register slices.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   bus       : lifo_stack_if.slave (requests in, array command/status out)
//   state_dbg : current FSM state (0 EMPTY, 1 PARTIAL, 2 FULL, 3 FLUSH)
// Array command encoding on sr_mode:
//   00 hold
//   01 shift-down / push (top <= sr_din)
//   10 shift-up / pop (bottom <= 0)
//   11 load top only
module lifo_stack_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  lifo_stack_if.slave bus,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_PUSH = 2'b01;
  localparam logic [1:0] M_POP  = 2'b10;
  localparam logic [1:0] M_LOAD = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;
  logic             overflow_q;
  logic             underflow_q;
  logic [1:0]       mode;

  // The array command has to act in the same cycle the request is seen, so it is
  // decoded combinationally. It follows the same priority order as the FSM below.
  always_comb begin
    mode = M_HOLD;
    if (state == S_FLUSH) begin
      mode = M_POP;
    end else if (bus.flush) begin
      mode = M_HOLD;                        // The drain begins on the next cycle.
    end else if (bus.push && bus.pop) begin
      mode = (state == S_EMPTY) ? M_PUSH : M_LOAD;
    end else if (bus.push) begin
      mode = (state == S_FULL) ? M_HOLD : M_PUSH;
    end else if (bus.pop) begin
      mode = (state == S_EMPTY) ? M_HOLD : M_POP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_EMPTY;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      // The clear is written first, so an error in the same cycle overrides it.
      if (bus.err_clr) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end
      case (state)
        S_FLUSH: begin
          // One entry leaves per cycle. Reaching zero ends the drain.
          if (count_q <= ONE_C) begin
            count_q <= '0;
            state   <= S_EMPTY;
          end else begin
            count_q <= count_q - ONE_C;
          end
        end
        default: begin
          if (bus.flush) begin
            if (state != S_EMPTY) state <= S_FLUSH;
          end else if (bus.push && bus.pop) begin
            if (state == S_EMPTY) begin
              count_q <= ONE_C;
              state   <= (ONE_C == DEPTH_C) ? S_FULL : S_PARTIAL;
            end else begin
              // The top entry is replaced. The old top is returned.
              dout_q       <= bus.sr_top;
              dout_valid_q <= 1'b1;
            end
          end else if (bus.push) begin
            if (state == S_FULL) begin
              overflow_q <= 1'b1;
            end else begin
              count_q <= count_q + ONE_C;
              state   <= ((count_q + ONE_C) == DEPTH_C) ? S_FULL : S_PARTIAL;
            end
          end else if (bus.pop) begin
            if (state == S_EMPTY) begin
              underflow_q <= 1'b1;
            end else begin
              dout_q       <= bus.sr_top;
              dout_valid_q <= 1'b1;
              count_q      <= count_q - ONE_C;
              state        <= (count_q == ONE_C) ? S_EMPTY : S_PARTIAL;
            end
          end
        end
      endcase
    end
  end

  assign bus.sr_mode    = mode;
  assign bus.sr_din     = bus.din;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.count      = count_q;
  assign bus.empty      = (state == S_EMPTY);
  assign bus.full       = (state == S_FULL);
  assign bus.busy       = (state == S_FLUSH);
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_lifo_stack_ctrl.sv
module tb_lifo_stack_ctrl;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;
  int         n_assert = 0;
  int         n_fail   = 0;

  lifo_stack_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  lifo_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Clock block
  always #5 clk = ~clk;

  // Behavioural model of the shift-register array that the controller commands.
  logic [WIDTH-1:0] arr [DEPTH];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) arr[i] <= '0;
    end else begin
      case (bus.sr_mode)
        2'b01: begin
          for (int i = 1; i < DEPTH; i++) arr[i] <= arr[i-1];
          arr[0] <= bus.sr_din;
        end
        2'b10: begin
          for (int i = 0; i < DEPTH - 1; i++) arr[i] <= arr[i+1];
          arr[DEPTH-1] <= '0;
        end
        2'b11: arr[0] <= bus.sr_din;
        default: ;
      endcase
    end
  end
  assign bus.sr_top = arr[0];

  // Driver tasks
  task automatic drive(input logic pu, input logic po, input logic fl,
                       input logic ec, input logic rs, input logic [3:0] d);
    bus.push    = pu;
    bus.pop     = po;
    bus.flush   = fl;
    bus.err_clr = ec;
    rst         = rs;
    bus.din     = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0;
    bus.err_clr = 1'b0; bus.din = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_dvalid", 32'(bus.dout_valid), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_udf", 32'(bus.underflow), 0);
    chk("rst_state", 32'(state_dbg), 0);

    // Fill the stack with 1..8
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, 0, 0, 0, 4'(i));
      chk("push_mode", 32'(bus.sr_mode), 32'h1);
      tick();
      chk("push_count", 32'(bus.count), 32'(i));
      chk("push_full", 32'(bus.full), (i == 8) ? 32'd1 : 32'd0);
    end
    chk("full_state", 32'(state_dbg), 2);

    // Overflow
    drive(1, 0, 0, 0, 0, 4'hf);
    chk("ovf_mode", 32'(bus.sr_mode), 0);
    tick();
    chk("ovf_flag", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 8);

    // Drain by popping; data comes back in LIFO order
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, 0, 0, 0, 4'h0);
      chk("pop_mode", 32'(bus.sr_mode), 32'h2);
      tick();
      chk("pop_dvalid", 32'(bus.dout_valid), 1);
      chk("pop_dout", 32'(bus.dout), 32'(9 - i));
      chk("pop_count", 32'(bus.count), 32'(8 - i));
    end
    chk("drain_empty", 32'(bus.empty), 1);
    drive(0, 0, 0, 0, 0, 4'h0);
    tick();
    chk("idle_dvalid", 32'(bus.dout_valid), 0);
    chk("idle_dout_hold", 32'(bus.dout), 1);

    // Underflow, then err_clr combined with another error
    drive(0, 1, 0, 0, 0, 4'h0);
    chk("udf_mode", 32'(bus.sr_mode), 0);
    tick();
    chk("udf_flag", 32'(bus.underflow), 1);
    chk("udf_dvalid", 32'(bus.dout_valid), 0);
    drive(0, 1, 0, 1, 0, 4'h0);
    tick();
    chk("udf_set_wins", 32'(bus.underflow), 1);
    chk("ovf_cleared", 32'(bus.overflow), 0);
    drive(0, 0, 0, 1, 0, 4'h0);
    tick();
    chk("udf_cleared", 32'(bus.underflow), 0);

    // Replace the top entry with a simultaneous push and pop
    drive(1, 0, 0, 0, 0, 4'h3); tick();
    drive(1, 0, 0, 0, 0, 4'h5); tick();
    drive(1, 1, 0, 0, 0, 4'ha);
    chk("repl_mode", 32'(bus.sr_mode), 32'h3);
    tick();
    chk("repl_dout", 32'(bus.dout), 32'h5);
    chk("repl_dvalid", 32'(bus.dout_valid), 1);
    chk("repl_count", 32'(bus.count), 2);
    drive(0, 1, 0, 0, 0, 4'h0); tick();
    chk("repl_pop", 32'(bus.dout), 32'ha);
    drive(0, 1, 0, 0, 0, 4'h0); tick();
    chk("repl_pop2", 32'(bus.dout), 32'h3);
    chk("repl_empty", 32'(bus.empty), 1);

    // Push and pop together on an empty stack behaves as a push
    drive(1, 1, 0, 0, 0, 4'h9);
    chk("pp_empty_mode", 32'(bus.sr_mode), 32'h1);
    tick();
    chk("pp_empty_count", 32'(bus.count), 1);
    chk("pp_empty_udf", 32'(bus.underflow), 0);
    drive(0, 1, 0, 0, 0, 4'h0); tick();
    chk("pp_empty_pop", 32'(bus.dout), 32'h9);

    // Flush a stack of 5; push asserted during the drain is ignored
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 0, 0, 0, 4'(i)); tick();
    end
    drive(0, 0, 1, 0, 0, 4'h0);
    chk("flush_req_mode", 32'(bus.sr_mode), 0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 1, 0, 0, 4'h7);
      chk("flush_busy", 32'(bus.busy), 1);
      chk("flush_mode", 32'(bus.sr_mode), 32'h2);
      tick();
      chk("flush_count", 32'(bus.count), 32'(5 - i));
      chk("flush_dvalid", 32'(bus.dout_valid), 0);
    end
    chk("flush_done_busy", 32'(bus.busy), 0);
    chk("flush_done_state", 32'(state_dbg), 0);
    chk("flush_no_ovf", 32'(bus.overflow), 0);

    // Flush on an empty stack does nothing
    drive(0, 0, 1, 0, 0, 4'h0); tick();
    chk("flush_empty_busy", 32'(bus.busy), 0);

    // Reset during a flush
    drive(0, 1, 0, 0, 0, 4'h0); tick();   // sets underflow
    for (int i = 1; i <= 6; i++) begin
      drive(1, 0, 0, 0, 0, 4'(i)); tick();
    end
    drive(0, 0, 1, 0, 0, 4'h0); tick();
    drive(0, 0, 0, 0, 0, 4'h0); tick();   // 1st flush cycle
    chk("mid_flush_count", 32'(bus.count), 5);
    drive(0, 0, 0, 0, 1, 4'h0); tick();   // rst on 2nd flush cycle
    chk("rf_count", 32'(bus.count), 0);
    chk("rf_busy", 32'(bus.busy), 0);
    chk("rf_udf", 32'(bus.underflow), 0);
    chk("rf_empty", 32'(bus.empty), 1);
    chk("rf_state", 32'(state_dbg), 0);
    drive(0, 0, 0, 0, 0, 4'h0); tick();

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/lifo_stack_ctrl.md
Name: lifo_stack_ctrl

Overview:
- Controller that sequences the 8-deep x 4-bit LIFO built from the bidirectional shift-register slices (each slice is a chain of D flip-flops).
- Converts push/pop/flush requests into per-cycle shift-mode commands for the register array.
- Tracks occupancy, drives full/empty flags, and registers popped data.
- Flags overflow/underflow misuse with sticky bits.

Parameters:
- WIDTH, 4, data bits per stack entry (width of one shift-register slice)
- DEPTH, 8, number of stack entries; legal range 2..15
- CNT_W, 4, occupancy counter width; must satisfy 2^CNT_W > DEPTH

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- push  in  1  push request, sampled every cycle
- pop  in  1  pop request, sampled every cycle
- flush  in  1  start a drain of all entries
- err_clr  in  1  clears the sticky overflow/underflow flags
- din  in  WIDTH  data to push
- sr_top  in  WIDTH  current top-entry value from the array
- sr_mode  out  2  array command: 00 hold, 01 shift-down/push (top<=sr_din), 10 shift-up/pop (bottom<=0), 11 load top only
- sr_din  out  WIDTH  data presented to the array top
- dout  out  WIDTH  registered popped data
- dout_valid  out  1  one-cycle pulse, dout valid
- count  out  CNT_W  current occupancy, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- busy  out  1  high while in FLUSH; requests are ignored
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty

Behaviour:
- All state changes occur on the rising clk edge.
- rst has priority over everything, including mid-flush. After reset:
  - state=EMPTY, count=0, dout=0, dout_valid=0, overflow=0, underflow=0, busy=0, empty=1, full=0.
- sr_mode and sr_din are combinational from state and inputs. sr_din=din always.
- FSM states:
  - EMPTY: count==0.
  - PARTIAL: 0<count<DEPTH.
  - FULL: count==DEPTH.
  - FLUSH: draining.
- empty and full are decoded from state. count is a registered counter.
- Request priority outside FLUSH: flush > (push and pop) > push > pop.
- flush with count>0:
  - Go to FLUSH.
  - Each FLUSH cycle: sr_mode=10, count decrements, no dout_valid.
  - On the cycle count reaches 0, the next state is EMPTY.
  - Drain takes count cycles.
- flush with count==0: no action; stay in EMPTY.
- busy=1 in every FLUSH cycle. push, pop and flush are ignored in FLUSH and do not set the error flags.
- push only:
  - Not FULL: sr_mode=01; count+1 at the edge. PARTIAL->FULL when count reaches DEPTH.
  - FULL: sr_mode=00; overflow<=1; count unchanged.
- pop only:
  - Not EMPTY: sr_mode=10; dout<=sr_top at the same edge; dout_valid=1 in the following cycle; count-1.
  - EMPTY: sr_mode=00; underflow<=1; no dout_valid.
- push and pop together:
  - Not EMPTY: replace the top entry. sr_mode=11; dout<=sr_top (the old top); dout_valid next cycle; count unchanged.
  - EMPTY: act as push only. sr_mode=01; count=1; underflow not set.
- Latency:
  - pop to dout_valid is exactly 1 cycle.
  - Back-to-back pops give consecutive dout_valid pulses in LIFO order.
- dout holds its last value when dout_valid=0.
- err_clr clears both sticky flags at the edge. If an error occurs in the same cycle, the set wins.
- count never wraps: no decrement below 0, no increment above DEPTH.

Test Plan:
- Reset, then push 0x1..0x8 on 8 consecutive cycles -> count 1..8; full=1 after the 8th; sr_mode=01 each cycle.
- From full, a 9th push of 0xF -> sr_mode=00, overflow=1, count=8. Then pop 8 times -> dout 0x8,0x7..0x1, each with dout_valid 1 cycle after the pop; empty=1 at the end.
- Pop when empty -> underflow=1, no dout_valid. Then err_clr together with another empty pop -> underflow stays 1. err_clr alone -> underflow=0.
- Push 0x3 then 0x5, then push 0xA with pop in the same cycle -> sr_mode=11, dout=0x5, count=2. Then pop -> dout=0xA.
- Push 5 entries, then flush -> busy high for 5 cycles with sr_mode=10; no dout_valid; push asserted during FLUSH is ignored; count=0, state=EMPTY.
- Assert rst on the 2nd cycle of a flush from count=6 -> count=0, busy=0, flags cleared on the next cycle.
